// File: rtl/rvfi_trace_buffer_if.sv
// Bundle of retirement inputs, packet output handshake and status for
// rvfi_trace_buffer. Optional out_cycle exists only when
// RVFI_TRACE_TIMESTAMP_EN is defined.
interface rvfi_trace_buffer_if #(
    parameter int XLEN = 32,
    parameter int NRET = 1
);
    // Retirement side, one slot per lane
    logic [NRET-1:0]           ret_valid;
    logic [NRET-1:0][XLEN-1:0] ret_pc;
    logic [NRET-1:0][XLEN-1:0] ret_pc_nxt;
    logic [NRET-1:0][31:0]     ret_insn;
    logic [NRET-1:0]           ret_trap;
    logic [NRET-1:0][4:0]      ret_rd;
    logic [NRET-1:0][XLEN-1:0] ret_rd_val;
    logic [NRET-1:0]           ret_is_load;
    logic [NRET-1:0]           ret_is_store;
    logic [NRET-1:0][1:0]      ret_size;
    logic [NRET-1:0][XLEN-1:0] ret_addr;
    logic [NRET-1:0][XLEN-1:0] ret_wdata;
    logic [NRET-1:0][XLEN-1:0] ret_rdata;
    logic                      halt;

    // Packet output side
    logic                      out_valid;
    logic                      out_ready;
    logic [63:0]               out_order;
    logic [XLEN-1:0]           out_pc;
    logic [XLEN-1:0]           out_pc_nxt;
    logic [31:0]               out_insn;
    logic                      out_trap;
    logic [4:0]                out_rd_addr;
    logic [XLEN-1:0]           out_rd_wdata;
    logic [XLEN-1:0]           out_mem_addr;
    logic [XLEN/8-1:0]         out_mem_rmask;
    logic [XLEN/8-1:0]         out_mem_wmask;
    logic [XLEN-1:0]           out_mem_rdata;
    logic [XLEN-1:0]           out_mem_wdata;
`ifdef RVFI_TRACE_TIMESTAMP_EN
    logic [31:0]               out_cycle;
`endif

    // Status
    logic                      drained;
    logic                      ovf_sticky;
    logic [15:0]               ovf_count;

    // Core/bench side: drives retirements and out_ready
    modport master (
        output ret_valid, ret_pc, ret_pc_nxt, ret_insn, ret_trap, ret_rd,
               ret_rd_val, ret_is_load, ret_is_store, ret_size, ret_addr,
               ret_wdata, ret_rdata, halt, out_ready,
        input  out_valid, out_order, out_pc, out_pc_nxt, out_insn, out_trap,
               out_rd_addr, out_rd_wdata, out_mem_addr, out_mem_rmask,
               out_mem_wmask, out_mem_rdata, out_mem_wdata,
               drained, ovf_sticky, ovf_count
`ifdef RVFI_TRACE_TIMESTAMP_EN
        , input out_cycle
`endif
    );

    // Trace buffer side
    modport slave (
        input  ret_valid, ret_pc, ret_pc_nxt, ret_insn, ret_trap, ret_rd,
               ret_rd_val, ret_is_load, ret_is_store, ret_size, ret_addr,
               ret_wdata, ret_rdata, halt, out_ready,
        output out_valid, out_order, out_pc, out_pc_nxt, out_insn, out_trap,
               out_rd_addr, out_rd_wdata, out_mem_addr, out_mem_rmask,
               out_mem_wmask, out_mem_rdata, out_mem_wdata,
               drained, ovf_sticky, ovf_count
`ifdef RVFI_TRACE_TIMESTAMP_EN
        , output out_cycle
`endif
    );
endinterface

// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: sanitises up to NRET retirements per cycle
// into trace packets, numbers them, and queues them in a DEPTH-entry FIFO.
// A retirement cycle that does not fit is dropped as a whole and counted.
// halt stops intake and tracks RUN -> DRAIN -> DONE as the FIFO empties.
// Optional build macro RVFI_TRACE_TIMESTAMP_EN adds a free-running cycle
// stamp to each packet (out_cycle).
module rvfi_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int NRET  = 1,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rvfi_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = XLEN / 8;

    typedef struct packed {
        logic [63:0]     order;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_nxt;
        logic [31:0]     insn;
        logic            trap;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] mem_addr;
        logic [MW-1:0]   rmask;
        logic [MW-1:0]   wmask;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] wdata;
`ifdef RVFI_TRACE_TIMESTAMP_EN
        logic [31:0]     cycle;
`endif
    } pkt_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    // Byte-lane mask for an access size; doubleword has no lanes on RV32
    function automatic logic [MW-1:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = (XLEN == 64) ? 8'hFF : 8'h00;
        endcase
        return m[MW-1:0];
    endfunction

    state_t          state_q;
    logic            drained_q;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [63:0]     order_q;
    logic            ovf_sticky_q;
    logic [15:0]     ovf_count_q;
    pkt_t            mem_q [DEPTH];

    pkt_t            lane_pkt [NRET];
    logic [AW-1:0]   lane_off [NRET];
    logic [CW-1:0]   n_valid;
    logic [CW-1:0]   free;
    logic            accept_en, ovf, push, pop;
    pkt_t            head;

`ifdef RVFI_TRACE_TIMESTAMP_EN
    logic [31:0]     cyc_q;

    // Free-running cycle stamp, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= '0;
        else        cyc_q <= cyc_q + 32'd1;
    end
`endif

    // Per-lane sanitised packet and its slot offset among this cycle's valid lanes
    always_comb begin
        n_valid = '0;
        for (int l = 0; l < NRET; l++) begin
            lane_off[l]          = n_valid[AW-1:0];
            lane_pkt[l]          = '0;
            lane_pkt[l].order    = order_q + 64'(n_valid);
            lane_pkt[l].pc       = bus.ret_pc[l];
            lane_pkt[l].pc_nxt   = bus.ret_pc_nxt[l];
            lane_pkt[l].insn     = bus.ret_insn[l];
            lane_pkt[l].trap     = bus.ret_trap[l];
            // A trapped instruction writes no register
            lane_pkt[l].rd_addr  = bus.ret_trap[l] ? 5'd0 : bus.ret_rd[l];
            lane_pkt[l].rd_wdata = (lane_pkt[l].rd_addr == 5'd0) ? '0 : bus.ret_rd_val[l];
            lane_pkt[l].rmask    = (bus.ret_is_load[l] && !bus.ret_trap[l])
                                   ? size_mask(bus.ret_size[l]) : '0;
            lane_pkt[l].wmask    = (bus.ret_is_store[l] && !bus.ret_trap[l])
                                   ? size_mask(bus.ret_size[l]) : '0;
            // Memory fields only carry meaning when some byte lane is active
            if ((lane_pkt[l].rmask | lane_pkt[l].wmask) != '0) begin
                lane_pkt[l].mem_addr = bus.ret_addr[l];
                lane_pkt[l].rdata    = bus.ret_rdata[l];
                lane_pkt[l].wdata    = bus.ret_wdata[l];
            end
`ifdef RVFI_TRACE_TIMESTAMP_EN
            lane_pkt[l].cycle    = cyc_q;
`endif
            if (bus.ret_valid[l]) n_valid = n_valid + CW'(1);
        end
    end

    // Admission uses start-of-cycle occupancy, so a same-cycle pop never makes room
    assign accept_en = (state_q == RUN) && !bus.halt;
    assign free      = CW'(DEPTH) - cnt_q;
    assign ovf       = accept_en && (n_valid > free);
    assign push      = accept_en && !ovf && (n_valid != '0);
    assign pop       = (cnt_q != '0) && bus.out_ready;
    assign cnt_d     = cnt_q + (push ? n_valid : '0) - CW'(pop);

    // Pointers, occupancy, order numbering and overflow bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            order_q      <= '0;
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                wptr_q  <= wptr_q + n_valid[AW-1:0];
                order_q <= order_q + 64'(n_valid);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
            if (ovf) begin
                ovf_sticky_q <= 1'b1;
                if (ovf_count_q != 16'hFFFF) ovf_count_q <= ovf_count_q + 16'd1;
            end
        end
    end

    // Packet storage; only occupied slots are ever presented, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            for (int l = 0; l < NRET; l++) begin
                if (bus.ret_valid[l]) mem_q[wptr_q + lane_off[l]] <= lane_pkt[l];
            end
        end
    end

    // Halt sequencing; drained is registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            drained_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.halt) begin
                        if (cnt_q != '0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q   <= DONE;
                            drained_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.halt) begin
                        state_q <= RUN;
                    end else if (cnt_d == '0) begin
                        state_q   <= DONE;
                        drained_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.halt) begin
                        state_q   <= RUN;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    // Oldest entry, forced to zero while empty so outputs read 0 in reset too
    assign head = (cnt_q != '0) ? mem_q[rptr_q] : '0;

    assign bus.out_valid     = (cnt_q != '0);
    assign bus.out_order     = head.order;
    assign bus.out_pc        = head.pc;
    assign bus.out_pc_nxt    = head.pc_nxt;
    assign bus.out_insn      = head.insn;
    assign bus.out_trap      = head.trap;
    assign bus.out_rd_addr   = head.rd_addr;
    assign bus.out_rd_wdata  = head.rd_wdata;
    assign bus.out_mem_addr  = head.mem_addr;
    assign bus.out_mem_rmask = head.rmask;
    assign bus.out_mem_wmask = head.wmask;
    assign bus.out_mem_rdata = head.rdata;
    assign bus.out_mem_wdata = head.wdata;
`ifdef RVFI_TRACE_TIMESTAMP_EN
    assign bus.out_cycle     = head.cycle;
`endif
    assign bus.drained       = drained_q;
    assign bus.ovf_sticky    = ovf_sticky_q;
    assign bus.ovf_count     = ovf_count_q;
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer (XLEN=32, NRET=2, DEPTH=8): directed scenarios
// plus a randomized phase, all checked against a queue-based packet model.
module tb_rvfi_trace_buffer;
    localparam int XLEN  = 32;
    localparam int NRET  = 2;
    localparam int DEPTH = 8;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rvfi_trace_buffer_if #(.XLEN(XLEN), .NRET(NRET)) bus ();

    rvfi_trace_buffer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] order;
        logic [31:0] pc, pc_nxt, insn;
        logic        trap;
        logic [4:0]  rd;
        logic [31:0] rd_wdata, addr;
        logic [3:0]  rmask, wmask;
        logic [31:0] rdata, wdata, cycle;
    } exp_t;

    // Model state: expected FIFO contents and counters
    exp_t        q[$];
    logic [63:0] order_m;
    int unsigned ovf_m;
    bit          sticky_m;
    int          mode_m;
    int unsigned cyc_m;
    int          checks, failures;

    logic [3:0] mask_tbl [4] = '{4'h1, 4'h3, 4'hF, 4'h0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        order_m  = '0;
        ovf_m    = 0;
        sticky_m = 0;
        mode_m   = M_RUN;
        cyc_m    = 0;
    endtask

    task automatic clear_inputs();
        bus.ret_valid = '0;   bus.ret_pc = '0;      bus.ret_pc_nxt = '0;
        bus.ret_insn = '0;    bus.ret_trap = '0;    bus.ret_rd = '0;
        bus.ret_rd_val = '0;  bus.ret_is_load = '0; bus.ret_is_store = '0;
        bus.ret_size = '0;    bus.ret_addr = '0;    bus.ret_wdata = '0;
        bus.ret_rdata = '0;   bus.halt = 1'b0;      bus.out_ready = 1'b0;
    endtask

    task automatic rand_lanes();
        for (int l = 0; l < NRET; l++) begin
            bus.ret_valid[l]    = 1'($urandom_range(0, 1));
            bus.ret_pc[l]       = $urandom;
            bus.ret_pc_nxt[l]   = $urandom;
            bus.ret_insn[l]     = $urandom;
            bus.ret_trap[l]     = ($urandom_range(0, 7) == 0);
            bus.ret_rd[l]       = 5'($urandom);
            bus.ret_rd_val[l]   = $urandom;
            bus.ret_is_load[l]  = 1'($urandom_range(0, 1));
            bus.ret_is_store[l] = 1'($urandom_range(0, 1));
            bus.ret_size[l]     = 2'($urandom);
            bus.ret_addr[l]     = $urandom;
            bus.ret_wdata[l]    = $urandom;
            bus.ret_rdata[l]    = $urandom;
        end
    endtask

    // Compare every DUT output against the model's view of the FIFO head
    task automatic check_outputs();
        exp_t h;
        h = '{default: '0};
        if (q.size() > 0) h = q[0];
        chk("out_valid",  64'(bus.out_valid),  64'(q.size() > 0));
        chk("drained",    64'(bus.drained),    64'(mode_m == M_DONE));
        chk("ovf_count",  64'(bus.ovf_count),  64'(ovf_m));
        chk("ovf_sticky", 64'(bus.ovf_sticky), 64'(sticky_m));
        chk("out_order",  bus.out_order,       h.order);
        chk("out_pc",     64'(bus.out_pc),     64'(h.pc));
        chk("out_pc_nxt", 64'(bus.out_pc_nxt), 64'(h.pc_nxt));
        chk("out_insn",   64'(bus.out_insn),   64'(h.insn));
        chk("out_trap",   64'(bus.out_trap),   64'(h.trap));
        chk("out_rd",     64'(bus.out_rd_addr), 64'(h.rd));
        chk("out_rd_wd",  64'(bus.out_rd_wdata), 64'(h.rd_wdata));
        chk("out_maddr",  64'(bus.out_mem_addr), 64'(h.addr));
        chk("out_rmask",  64'(bus.out_mem_rmask), 64'(h.rmask));
        chk("out_wmask",  64'(bus.out_mem_wmask), 64'(h.wmask));
        chk("out_rdata",  64'(bus.out_mem_rdata), 64'(h.rdata));
        chk("out_wdata",  64'(bus.out_mem_wdata), 64'(h.wdata));
`ifdef RVFI_TRACE_TIMESTAMP_EN
        chk("out_cycle",  64'(bus.out_cycle), 64'(h.cycle));
`endif
    endtask

    // One clock: predict from pre-edge inputs, advance, then check
    task automatic step();
        int   sz_pre  = q.size();
        bit   do_pop  = (sz_pre > 0) && bus.out_ready;
        bit   halt_pre = bus.halt;
        exp_t pend[$];
        exp_t e;
        if (mode_m == M_RUN && !halt_pre) begin
            for (int l = 0; l < NRET; l++) begin
                if (bus.ret_valid[l]) begin
                    e = '{default: '0};
                    e.pc     = bus.ret_pc[l];
                    e.pc_nxt = bus.ret_pc_nxt[l];
                    e.insn   = bus.ret_insn[l];
                    e.trap   = bus.ret_trap[l];
                    e.rd     = e.trap ? 5'd0 : bus.ret_rd[l];
                    e.rd_wdata = (e.rd == 0) ? 32'd0 : bus.ret_rd_val[l];
                    e.rmask  = (bus.ret_is_load[l] && !e.trap) ? mask_tbl[bus.ret_size[l]] : 4'h0;
                    e.wmask  = (bus.ret_is_store[l] && !e.trap) ? mask_tbl[bus.ret_size[l]] : 4'h0;
                    if (e.rmask != 0 || e.wmask != 0) begin
                        e.addr  = bus.ret_addr[l];
                        e.rdata = bus.ret_rdata[l];
                        e.wdata = bus.ret_wdata[l];
                    end
                    e.cycle  = cyc_m;
                    pend.push_back(e);
                end
            end
            if (pend.size() > DEPTH - sz_pre) begin
                pend.delete();
                sticky_m = 1;
                if (ovf_m < 32'hFFFF) ovf_m++;
            end
        end
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        foreach (pend[i]) begin
            pend[i].order = order_m;
            order_m++;
            q.push_back(pend[i]);
        end
        case (mode_m)
            M_RUN:   if (halt_pre) mode_m = (sz_pre > 0) ? M_DRAIN : M_DONE;
            M_DRAIN: if (!halt_pre) mode_m = M_RUN; else if (q.size() == 0) mode_m = M_DONE;
            default: if (!halt_pre) mode_m = M_RUN;
        endcase
        cyc_m++;
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        reset_model();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        int pops;
        int cnt;
        int unsigned ovf0;
        logic [63:0] base;
        checks = 0;
        failures = 0;
        clear_inputs();
        reset_model();
        apply_reset();

        // Single load retirement, visible the cycle after
        bus.out_ready = 1'b1;
        bus.ret_valid = 2'b01;
        bus.ret_pc[0] = 32'h8000_0000;   bus.ret_pc_nxt[0] = 32'h8000_0004;
        bus.ret_insn[0] = 32'h1000_2283; bus.ret_rd[0] = 5'd5;
        bus.ret_rd_val[0] = 32'hDEAD_BEEF; bus.ret_is_load[0] = 1'b1;
        bus.ret_size[0] = 2'd2;          bus.ret_addr[0] = 32'h100;
        bus.ret_rdata[0] = 32'hDEAD_BEEF;
        step();
        chk("lw_valid", 64'(bus.out_valid), 64'd1);
        chk("lw_order", bus.out_order, 64'd0);
        chk("lw_rmask", 64'(bus.out_mem_rmask), 64'hF);
        chk("lw_wmask", 64'(bus.out_mem_wmask), 64'h0);
        chk("lw_rdwd",  64'(bus.out_rd_wdata), 64'hDEAD_BEEF);
        bus.ret_valid = '0;
        step();
        chk("lw_popped", 64'(bus.out_valid), 64'd0);

        // Nine retirements into eight slots with no consumer
        apply_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rand_lanes();
            bus.ret_valid = 2'b01;
            step();
        end
        chk("fill_ovf_count", 64'(bus.ovf_count), 64'd1);
        chk("fill_ovf_sticky", 64'(bus.ovf_sticky), 64'd1);
        bus.ret_valid = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_order", bus.out_order, 64'(i));
            step();
        end
        chk("fill_empty", 64'(bus.out_valid), 64'd0);

        // Dual lane: store byte on lane 0, trap on lane 1
        clear_inputs();
        bus.ret_valid = 2'b11;
        bus.ret_is_store[0] = 1'b1; bus.ret_size[0] = 2'd0;
        bus.ret_addr[0] = 32'h203;  bus.ret_wdata[0] = 32'h55;
        bus.ret_trap[1] = 1'b1;     bus.ret_rd[1] = 5'd3;
        bus.ret_rd_val[1] = 32'h1234; bus.ret_is_load[1] = 1'b1;
        bus.ret_size[1] = 2'd2;     bus.ret_addr[1] = 32'h400;
        bus.ret_rdata[1] = 32'h77;
        base = 64'd8;
        step();
        chk("dual_l0_order", bus.out_order, base);
        chk("dual_l0_wmask", 64'(bus.out_mem_wmask), 64'h1);
        bus.ret_valid = '0;
        bus.out_ready = 1'b1;
        step();
        chk("dual_l1_order", bus.out_order, base + 64'd1);
        chk("dual_l1_rd",    64'(bus.out_rd_addr), 64'd0);
        chk("dual_l1_wmask", 64'(bus.out_mem_wmask), 64'd0);
        chk("dual_l1_maddr", 64'(bus.out_mem_addr), 64'd0);
        chk("dual_l1_rdata", 64'(bus.out_mem_rdata), 64'd0);
        step();

        // Occupancy 7, two lanes arrive while one pops: all dropped
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_lanes();
            bus.ret_valid = 2'b01;
            step();
        end
        ovf0 = 32'(bus.ovf_count);
        rand_lanes();
        bus.ret_valid = 2'b11;
        bus.out_ready = 1'b1;
        step();
        chk("pop_no_room_ovf", 64'(bus.ovf_count), 64'(ovf0 + 1));
        bus.ret_valid = '0;
        cnt = 0;
        for (int i = 0; i < 20 && bus.out_valid; i++) begin
            cnt++;
            step();
        end
        chk("pop_no_room_occ", 64'(cnt), 64'd6);

        // Halt with four entries, consumer toggling
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_lanes();
            bus.ret_valid = 2'b11;
            step();
        end
        bus.halt = 1'b1;
        pops = 0;
        for (int i = 0; i < 20 && pops < 4; i++) begin
            rand_lanes();
            bus.ret_valid = 2'b11;
            bus.out_ready = 1'(i % 2);
            chk("halt_not_drained", 64'(bus.drained), 64'd0);
            if (bus.out_valid && bus.out_ready) pops++;
            step();
        end
        chk("halt_pops", 64'(pops), 64'd4);
        chk("halt_drained", 64'(bus.drained), 64'd1);
        chk("halt_ignored", 64'(bus.out_valid), 64'd0);
        bus.halt = 1'b0;
        bus.ret_valid = '0;
        step();
        chk("resume_run", 64'(bus.drained), 64'd0);
        rand_lanes();
        bus.ret_valid = 2'b01;
        bus.out_ready = 1'b0;
        step();
        chk("resume_accept", 64'(bus.out_valid), 64'd1);

        // Randomized traffic with occasional halt bursts
        for (int i = 0; i < 600; i++) begin
            rand_lanes();
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 31) == 0) bus.halt = ~bus.halt;
            step();
        end
        clear_inputs();

        // Reset pulsed while draining three entries
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_lanes();
            bus.ret_valid = 2'b01;
            step();
        end
        bus.ret_valid = '0;
        bus.halt = 1'b1;
        step();
        chk("drain_pre_rst", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_async_drained", 64'(bus.drained), 64'd0);
        reset_model();
        check_outputs();
        bus.halt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rand_lanes();
        bus.ret_valid = 2'b01;
        step();
        chk("post_rst_order", bus.out_order, 64'd0);
`ifdef RVFI_TRACE_TIMESTAMP_EN
        chk("post_rst_cycle", 64'(bus.out_cycle), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
